// File: rtl/jump_command_gen.sv
// ---------------------------------------------------------------------------
// jump_command_gen
//
// Purpose:
//   Producer side of the player movement interface. Raw push buttons are
//   synchronised, debounced and edge-detected; simultaneous presses are
//   arbitrated (big > small > drop) and turned into a one-hot `operation`
//   command that is held until the first frame tick. The manoeuvre length is
//   then tracked in frame ticks so no new command is issued while a jump or
//   drop is still running.
//
// Ports:
//   clk        system clock, single clock domain
//   reset      asynchronous, active-high reset
//   enable     game running; low pauses the frame tick and all manoeuvres
//   key_big    raw button, active-high, asynchronous to clk
//   key_small  raw button, active-high, asynchronous to clk
//   key_drop   raw button, active-high, asynchronous to clk
//   operation  one-hot command: 001 big jump, 010 small jump, 100 drop
//   update     one-clk frame tick
//   busy       high while a manoeuvre is issued or in progress
//
// Optional feature (macro JUMP_CMD_BUFFER_EN):
//   When defined, the first arbitrated press seen while busy is held in a
//   one-deep pending register and issued as soon as the current manoeuvre
//   finishes. When undefined, presses while busy are discarded.
// ---------------------------------------------------------------------------
module jump_command_gen #(
  parameter int UPDATE_DIV      = 833334,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BIG_LEN         = 10,
  parameter int SMALL_LEN       = 15,
  parameter int DROP_LEN        = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       key_big,
  input  logic       key_small,
  input  logic       key_drop,
  output logic [2:0] operation,
  output logic       update,
  output logic       busy
);

  // A length of 0 would never complete, so it is promoted to 1.
  localparam int BIG_EFF   = (BIG_LEN   < 1) ? 1 : BIG_LEN;
  localparam int SMALL_EFF = (SMALL_LEN < 1) ? 1 : SMALL_LEN;
  localparam int DROP_EFF  = (DROP_LEN  < 1) ? 1 : DROP_LEN;
  localparam int MAX_A     = (BIG_EFF > SMALL_EFF) ? BIG_EFF : SMALL_EFF;
  localparam int MAX_LEN   = (MAX_A > DROP_EFF) ? MAX_A : DROP_EFF;

  localparam int STEP_W = $clog2(MAX_LEN + 1);
  localparam int TICK_W = $clog2(UPDATE_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [STEP_W-1:0] BIG_STEPS   = STEP_W'(BIG_EFF);
  localparam logic [STEP_W-1:0] SMALL_STEPS = STEP_W'(SMALL_EFF);
  localparam logic [STEP_W-1:0] DROP_STEPS  = STEP_W'(DROP_EFF);
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(UPDATE_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE} state_t;

  // Bit order for all per-key vectors: [0] big, [1] small, [2] drop.
  logic [2:0]        raw_keys, sync_meta, sync_keys, deb_keys, deb_prev, presses;
  logic [DEB_W-1:0]  deb_cnt [3];
  logic [2:0]        arb_op;
  logic              press_any;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_last;

  state_t            state, state_next;
  logic [2:0]        op_reg, op_next, launch_op;
  logic [STEP_W-1:0] len_reg, len_next, step, step_next, step_inc;
  logic              launch;

  function automatic logic [STEP_W-1:0] len_of(input logic [2:0] op);
    case (op)
      3'b001:  return BIG_STEPS;
      3'b010:  return SMALL_STEPS;
      default: return DROP_STEPS;
    endcase
  endfunction

  assign raw_keys = {key_drop, key_small, key_big};

  // Two-flop synchroniser bringing the asynchronous buttons into clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_keys <= '0;
    end else begin
      sync_meta <= raw_keys;
      sync_keys <= sync_meta;
    end
  end

  // Per-key debounce: the debounced state only flips after DEBOUNCE_CYCLES
  // consecutive samples disagree with it; any agreeing sample restarts the
  // count. deb_prev keeps last cycle's state for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_keys <= '0;
      deb_prev <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      deb_prev <= deb_keys;
      for (int i = 0; i < 3; i++) begin
        if (sync_keys[i] == deb_keys[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i]  <= '0;
          deb_keys[i] <= ~deb_keys[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign presses   = deb_keys & ~deb_prev;
  assign press_any = |presses;
  assign arb_op    = presses[0] ? 3'b001 :
                     presses[1] ? 3'b010 :
                     presses[2] ? 3'b100 : 3'b000;

  // Frame tick divider. It freezes while paused so a resumed game continues
  // from exactly the same phase; update is gated by enable so a frozen
  // terminal count cannot produce a stretched pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (enable) begin
      tick_cnt <= tick_last ? '0 : tick_cnt + TICK_W'(1);
    end
  end

  assign tick_last = (tick_cnt == TICK_LAST);
  assign update    = enable && tick_last;

`ifdef JUMP_CMD_BUFFER_EN
  logic [2:0] pend_op;
  logic       pend_take;

  // One-deep pending command: only the first press while busy is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_op <= '0;
    end else if (pend_take) begin
      pend_op <= '0;
    end else if (busy && press_any && (pend_op == 3'b000)) begin
      pend_op <= arb_op;
    end
  end
`endif

  // Manoeuvre state register together with the latched command, its length
  // and the number of frame ticks already completed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_reg  <= '0;
      len_reg <= '0;
      step    <= '0;
    end else begin
      state   <= state_next;
      op_reg  <= op_next;
      len_reg <= len_next;
      step    <= step_next;
    end
  end

  assign step_inc = step + STEP_W'(1);

  // Next-state logic. The update seen in ISSUE is step 1; the manoeuvre ends
  // on the update that completes step len_reg. A new command can only start
  // from a cycle whose next state would be IDLE, so a press coinciding with
  // the final update is lost unless the pending buffer is present.
  always_comb begin
    state_next = state;
    op_next    = op_reg;
    len_next   = len_reg;
    step_next  = step;
    launch     = 1'b0;
    launch_op  = arb_op;
`ifdef JUMP_CMD_BUFFER_EN
    pend_take  = 1'b0;
`endif
    case (state)
      IDLE: begin
        launch = enable && press_any;
      end
      ISSUE: begin
        if (update) begin
          step_next  = step_inc;
          state_next = (step_inc == len_reg) ? IDLE : ACTIVE;
        end
      end
      ACTIVE: begin
        if (update) begin
          step_next = step_inc;
          if (step_inc == len_reg) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef JUMP_CMD_BUFFER_EN
    if (enable && (pend_op != 3'b000) && (state_next == IDLE)) begin
      launch    = 1'b1;
      launch_op = pend_op;
      pend_take = 1'b1;
    end
`endif
    if (launch) begin
      state_next = ISSUE;
      op_next    = launch_op;
      len_next   = len_of(launch_op);
      step_next  = '0;
    end
  end

  assign busy      = (state != IDLE);
  assign operation = (state == ISSUE) ? op_reg : 3'b000;

endmodule

// File: tb/tb_jump_command_gen.sv
// ---------------------------------------------------------------------------
// tb_jump_command_gen
//
// Self-checking bench for jump_command_gen with UPDATE_DIV=4 and
// DEBOUNCE_CYCLES=3. Every expected command is pushed to a scoreboard queue
// when its key stimulus is driven; a negedge monitor pops an entry whenever
// operation rises, then counts frame ticks until the manoeuvre ends and
// compares the command code and its length in ticks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jump_command_gen;

  localparam int UPDATE_DIV      = 4;
  localparam int DEBOUNCE_CYCLES = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       key_big;
  logic       key_small;
  logic       key_drop;
  logic [2:0] operation;
  logic       update;
  logic       busy;

  typedef struct {
    logic [2:0] op;
    int         len;
  } exp_t;

  typedef struct {
    logic [2:0] keys;
    logic [2:0] op;
    int         len;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];

  int total = 0;
  int bad   = 0;

  logic       in_man = 1'b0;
  logic [2:0] cur_op = 3'b000;
  int         cur_len = 0;
  int         man_updates = 0;
  int         issue_updates = 0;
  logic [2:0] prev_op = 3'b000;
  logic       prev_update = 1'b0;

  jump_command_gen #(
    .UPDATE_DIV(UPDATE_DIV),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BIG_LEN(10),
    .SMALL_LEN(15),
    .DROP_LEN(9)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .key_big(key_big),
    .key_small(key_small),
    .key_drop(key_drop),
    .operation(operation),
    .update(update),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [2:0] op, input int len);
    exp_t e;
    e.op  = op;
    e.len = len;
    sb.push_back(e);
  endtask

  // Drive a key pattern for 10 clocks and record the command it should cause.
  task automatic applyStimulus(input logic [2:0] keys, input logic [2:0] op,
                               input int len);
    if (len > 0) pushExp(op, len);
    {key_drop, key_small, key_big} = keys;
    repeat (10) @(negedge clk);
    {key_drop, key_small, key_big} = 3'b000;
  endtask

  // Wait (bounded) for a manoeuvre to start and finish, then let released
  // keys settle through the debouncer.
  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_busy_rise"}, busy, 1);
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_busy_fall"}, busy, 0);
    repeat (12) @(negedge clk);
  endtask

  task automatic waitSteps(input int steps, input string name);
    int n;
    n = 0;
    while (!(in_man && man_updates >= steps) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, (in_man && man_updates >= steps), 1);
  endtask

  // Transaction monitor: closes a manoeuvre when busy falls or a new command
  // appears, opens one when operation rises, and counts frame ticks between.
  always @(negedge clk) begin
    if (reset) begin
      in_man      = 1'b0;
      prev_op     = 3'b000;
      prev_update = 1'b0;
    end else begin
      if (in_man && (busy == 1'b0 || (operation != 3'b000 && prev_op == 3'b000))) begin
        checkOutput("man_length", man_updates, cur_len);
        checkOutput("man_end_timing", prev_update, 1);
        checkOutput("man_issue_ticks", issue_updates, 1);
        in_man = 1'b0;
      end
      if (operation != 3'b000 && prev_op == 3'b000) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_op", operation, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("man_op", operation, e.op);
          in_man        = 1'b1;
          cur_op        = e.op;
          cur_len       = e.len;
          man_updates   = 0;
          issue_updates = 0;
        end
      end
      if (in_man) begin
        if (operation != 3'b000) checkOutput("op_hold", operation, cur_op);
        if (update) begin
          man_updates++;
          if (operation != 3'b000) issue_updates++;
        end
      end
      prev_op     = operation;
      prev_update = update;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int cnt;

    vecs[0] = '{keys: 3'b001, op: 3'b001, len: 10};
    vecs[1] = '{keys: 3'b010, op: 3'b010, len: 15};
    vecs[2] = '{keys: 3'b100, op: 3'b100, len: 9};
    vecs[3] = '{keys: 3'b101, op: 3'b001, len: 10};
    vecs[4] = '{keys: 3'b110, op: 3'b010, len: 15};
    vecs[5] = '{keys: 3'b011, op: 3'b001, len: 10};
    vecs[6] = '{keys: 3'b111, op: 3'b001, len: 10};

    reset     = 1'b1;
    enable    = 1'b0;
    key_big   = 1'b0;
    key_small = 1'b0;
    key_drop  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_operation", operation, 0);
    checkOutput("reset_update", update, 0);
    checkOutput("reset_busy", busy, 0);
    #2 reset = 1'b0;
    @(negedge clk);

    $display("[TB] tick generator");
    enable = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      checkOutput($sformatf("tick_%0d", k), update, (k % 4 == 3));
    end
    enable = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("tick_paused_%0d", k), update, 0);
    end
    enable = 1'b1;
    @(negedge clk);
    checkOutput("tick_resume", update, 1);

    $display("[TB] bouncing big key");
    pushExp(3'b001, 10);
    for (int c = 0; c < 10; c++) begin
      key_big = ((c / 2) % 2 == 0);
      @(negedge clk);
    end
    key_big = 1'b1;
    repeat (12) @(negedge clk);
    key_big = 1'b0;
    waitIdle("bounce");

    $display("[TB] single and simultaneous presses");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].keys, vecs[i].op, vecs[i].len);
      waitIdle($sformatf("row%0d", i));
      checkOutput($sformatf("row%0d_op_idle", i), operation, 0);
    end

    $display("[TB] press while busy");
    applyStimulus(3'b010, 3'b010, 15);
    waitSteps(5, "busydrop_step5");
    key_drop = 1'b1;
`ifdef JUMP_CMD_BUFFER_EN
    pushExp(3'b100, 9);
`endif
    repeat (10) @(negedge clk);
    key_drop = 1'b0;
    waitIdle("busydrop");

    $display("[TB] reset mid-jump");
    applyStimulus(3'b001, 3'b001, 10);
    waitSteps(4, "reset_step4");
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_operation", operation, 0);
    checkOutput("midreset_update", update, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("postreset_tick_%0d", k), update, (k == 3));
    end
    repeat (10) @(negedge clk);

    $display("[TB] pause during manoeuvre");
    applyStimulus(3'b001, 3'b001, 10);
    waitSteps(3, "pause_step3");
    enable = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (update) cnt++;
    end
    checkOutput("pause_busy", busy, 1);
    checkOutput("pause_updates", cnt, 0);
    checkOutput("pause_steps", man_updates, 3);
    enable = 1'b1;
    waitIdle("pause");

    $display("[TB] press while disabled");
    enable = 1'b0;
    key_small = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 12) key_small = 1'b0;
      if (busy || operation != 3'b000) cnt++;
    end
    checkOutput("disabled_press_ignored", cnt, 0);
    enable = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    checkOutput("disabled_press_not_replayed", cnt, 0);

    checkOutput("scoreboard_empty", sb.size(), 0);
    checkOutput("monitor_closed", in_man, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jump_command_gen.md
Name: jump_command_gen

Overview:
- Producer side of the player movement interface: turns raw push-button inputs into the 3-bit one-hot `operation` code and the `update` frame tick that the y-position updater consumes.
- Debounces the keys, detects presses and arbitrates simultaneous presses.
- Tracks each manoeuvre's length in update ticks, so no new command is issued while a jump or drop is still in progress.
- Sits between the board key inputs and the movement datapath.

Parameters:
- UPDATE_DIV, 833334, clk cycles per update tick (50 MHz / 60 Hz); minimum 2.
- DEBOUNCE_CYCLES, 500000, consecutive stable samples needed before a debounced key changes; minimum 1.
- BIG_LEN, 10, update ticks in a big jump.
- SMALL_LEN, 15, update ticks in a small jump.
- DROP_LEN, 9, update ticks in a drop.

Ports:
- clk  input  1  system clock, single clock domain.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  game running; low = pause.
- key_big  input  1  raw button, active-high, asynchronous to clk.
- key_small  input  1  raw button, active-high.
- key_drop  input  1  raw button, active-high.
- operation  output  3  one-hot command: 3'b001 big jump, 3'b010 small jump, 3'b100 drop, 3'b000 none.
- update  output  1  one-clk frame tick.
- busy  output  1  high while a manoeuvre is issued or in progress.

Behaviour:
- Reset (async, active-high):
  - operation=0, update=0, busy=0.
  - FSM to IDLE; tick counter and step counter cleared.
  - Synchronisers, debounced key states and debounce counters all cleared.
  - Reset mid-manoeuvre abandons it; there is no resumption after release.
- Synchroniser: each key passes through a 2-flop synchroniser.
- Debounce (per key):
  - The counter increments while the synchronised value differs from the debounced state, and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced state toggles and the counter clears.
- Press detect: a press is a debounced 0->1 transition, valid for one clk.
- Arbitration: simultaneous presses resolve as big > small > drop; losing presses are discarded.
- Tick generator:
  - Counter runs 0..UPDATE_DIV-1 only while enable=1 and holds while enable=0.
  - update=1 for exactly one clk when the counter equals UPDATE_DIV-1; the counter then wraps to 0.
- FSM states and transitions:
  - IDLE:
    - busy=0, operation=0.
    - A press with enable=1 latches the op code and its length (LEN), clears the step counter, and moves to ISSUE on the next clk.
    - A press with enable=0 is discarded.
  - ISSUE:
    - busy=1; operation drives the latched one-hot code.
    - Held until and including the clk in which update=1; that update is step 1.
    - Next state is ACTIVE, or IDLE if LEN==1.
  - ACTIVE:
    - busy=1, operation=0.
    - Each update increments the step counter.
    - On the update that completes step LEN, return to IDLE; busy falls the next clk.
- Presses in ISSUE or ACTIVE are dropped, not queued; the optional feature changes this.
- Pause: enable=0 freezes the tick counter, so ISSUE and ACTIVE hold their state with no timeout. Resuming continues from the frozen point.
- A press and the final update of a manoeuvre in the same clk: the press is dropped.
- Step counter is sized for the largest of the three lengths; any LEN of 0 is treated as 1.

Optional Feature:
- Macro: JUMP_CMD_BUFFER_EN.
- Defined:
  - A one-deep pending register captures the first arbitrated press while busy=1; later presses are dropped.
  - On the clk the FSM returns to IDLE with a pending entry and enable=1, it goes directly to ISSUE with the pending op, and the entry clears.
  - Reset clears the pending register.
- Undefined: presses while busy are discarded, as described in Behaviour.

Test Plan (UPDATE_DIV=4, DEBOUNCE_CYCLES=3, default lengths):
- Tick: enable=1 for 40 clk -> update pulses exactly every 4th clk, 10 pulses; enable=0 for 8 clk -> no pulses, and counter resumes from the held value.
- Bounce: key_big toggles every 2 clk for 10 clk, then holds 1 -> exactly one press, operation=3'b001 asserted until the next update, busy high for exactly 10 update ticks.
- Priority: key_big and key_drop rise in the same clk -> operation=3'b001 only; drop press discarded.
- Busy drop: key_small press, then key_drop press at step 5 -> drop ignored, busy high for 15 ticks then 0; JUMP_CMD_BUFFER_EN defined -> operation=3'b100 issued the clk after busy would fall, followed by 9 ticks.
- Reset mid-jump: reset=1 at step 4 of a big jump -> operation=0, busy=0, update=0 immediately (async); after release, no pulses until the tick counter counts from 0.
- Pause: enable=0 during ACTIVE at step 3 for 20 clk -> busy stays 1, no updates; re-enable -> completes the remaining 7 steps.
